// File: rtl/ariane_pkg.sv
// Shared performance-monitor definitions: CSR addresses, event indices,
// event-register layout and privilege encodings used by the HPM counter bank.
package ariane_pkg;

  localparam logic [11:0] CSR_MHPM_COUNTER_3  = 12'hB03;
  localparam logic [11:0] CSR_MHPM_COUNTER_3H = 12'hB83;
  localparam logic [11:0] CSR_MHPM_EVENT_3    = 12'h323;
  localparam logic [11:0] CSR_MHPM_EVENT_3H   = 12'h723;

  localparam int unsigned EV_NONE           = 0;
  localparam int unsigned EV_ICACHE_MISS    = 1;
  localparam int unsigned EV_DCACHE_MISS    = 2;
  localparam int unsigned EV_ITLB_MISS      = 3;
  localparam int unsigned EV_DTLB_MISS      = 4;
  localparam int unsigned EV_LOAD           = 5;
  localparam int unsigned EV_STORE          = 6;
  localparam int unsigned EV_EXCEPTION      = 7;
  localparam int unsigned EV_EXCEPTION_RET  = 8;
  localparam int unsigned EV_BRANCH         = 9;
  localparam int unsigned EV_BRANCH_MISPRED = 10;

  localparam int unsigned HPM_OF_BIT   = 63;
  localparam int unsigned HPM_MINH_BIT = 62;
  localparam int unsigned HPM_SINH_BIT = 61;
  localparam int unsigned HPM_UINH_BIT = 60;
  localparam int unsigned HPM_SEL_MAXW = 8;

  typedef struct packed {
    logic                    of;
    logic                    minh;
    logic                    sinh;
    logic                    uinh;
    logic [51:0]             rsvd;
    logic [HPM_SEL_MAXW-1:0] sel;
  } hpm_event_t;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } priv_lvl_e;

  // Inhibit bit of the event register that applies at the given privilege.
  function automatic logic priv_inhibit(hpm_event_t evt, logic [1:0] priv);
    case (priv)
      PRIV_M:  return evt.minh;
      PRIV_S:  return evt.sinh;
      PRIV_U:  return evt.uinh;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hpm_counter.sv
// One hardware performance counter: 64-bit count, event selector register,
// sticky overflow flag and the inhibit gating that decides whether it counts.
module hpm_counter
  import ariane_pkg::*;
#(
  parameter int unsigned NumEvents = 32,
  parameter int unsigned IncrWidth = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           debug_mode_i,
  input  logic [1:0]                     priv_lvl_i,
  input  logic                           inhibit_i,
  input  logic [NumEvents*IncrWidth-1:0] event_incr_i,
  input  logic                           cnt_we_i,
  input  logic [63:0]                    cnt_wdata_i,
  input  logic                           evt_we_i,
  input  logic [63:0]                    evt_wdata_i,
  output logic [63:0]                    cnt_o,
  output logic [63:0]                    evt_o,
  output logic                           of_o
);

  localparam int unsigned SelW = (NumEvents > 1) ? $clog2(NumEvents) : 1;

  logic [63:0]          cnt_q, cnt_d;
  hpm_event_t           evt_q, evt_d;
  logic [IncrWidth-1:0] incr;
  logic                 count_en;
  logic                 carry;
  logic [64:0]          sum;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    incr = '0;
    for (int e = 0; e < int'(NumEvents); e++) begin
      if (evt_q.sel == HPM_SEL_MAXW'(e)) incr = event_incr_i[e*IncrWidth +: IncrWidth];
    end

    count_en = (evt_q.sel != '0) && !inhibit_i && !debug_mode_i
               && !priv_inhibit(evt_q, priv_lvl_i);
    sum      = {1'b0, cnt_q} + {{(65-IncrWidth){1'b0}}, incr};

    cnt_d = cnt_q;
    carry = 1'b0;
    if (cnt_we_i) begin
      cnt_d = cnt_wdata_i;
    end else if (count_en) begin
      cnt_d = sum[63:0];
      carry = sum[64];
    end

    evt_d = evt_q;
    if (evt_we_i) begin
      evt_d      = '0;
      evt_d.of   = evt_wdata_i[HPM_OF_BIT];
      evt_d.minh = evt_wdata_i[HPM_MINH_BIT];
      evt_d.sinh = evt_wdata_i[HPM_SINH_BIT];
      evt_d.uinh = evt_wdata_i[HPM_UINH_BIT];
      // Out-of-range selectors fall back to "no event".
      evt_d.sel  = (evt_wdata_i[59:0] < 60'(NumEvents))
                   ? HPM_SEL_MAXW'(evt_wdata_i[SelW-1:0]) : '0;
    end
    // A hardware carry wins over a software clear in the same cycle.
    evt_d.of = evt_d.of | carry;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      evt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      evt_q <= evt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign evt_o = evt_q;
  assign of_o  = evt_q.of;

endmodule

// File: rtl/hpm_counter_bank.sv
// Bank of mhpmcounter3.. / mhpmevent3.. CSRs: address decode, read mux,
// RV32 half-word merging, overflow status view and the overflow interrupt.
module hpm_counter_bank
  import ariane_pkg::*;
#(
  parameter int unsigned NumCounters = 6,
  parameter int unsigned NumEvents   = 32,
  parameter int unsigned IncrWidth   = 3,
  parameter int unsigned XLEN        = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           debug_mode_i,
  input  logic [1:0]                     priv_lvl_i,
  input  logic [NumEvents*IncrWidth-1:0] event_incr_i,
  input  logic [31:0]                    mcountinhibit_i,
  input  logic [11:0]                    addr_i,
  input  logic                           we_i,
  input  logic [XLEN-1:0]                data_i,
  output logic [XLEN-1:0]                data_o,
  output logic                           access_err_o,
  output logic [31:0]                    ovf_status_o,
  output logic                           ovf_irq_o
);

  localparam bit          IsRv64   = (XLEN == 64);
  localparam logic [11:0] NumCnt12 = 12'(NumCounters);

  logic [63:0] cnt [NumCounters];
  logic [63:0] evt [NumCounters];
  logic [NumCounters-1:0] of_bits, cnt_we, evt_we;

  logic [11:0] off_cnt, off_cnth, off_evt, off_evth;
  logic        hit_cnt, hit_cnth, hit_evt, hit_evth;
  logic        sel_cnt, sel_hi, mapped;
  logic [4:0]  idx;
  logic [63:0] data_ext, rd_cnt, rd_evt, rd_cur, rd_word, wr_word;
  logic        ovf_irq_q, ovf_irq_d;
  logic        unused_inhibit;

  assign data_ext       = 64'(data_i);
  assign unused_inhibit = ^mcountinhibit_i;

  always_comb begin
    off_cnt  = addr_i - CSR_MHPM_COUNTER_3;
    off_cnth = addr_i - CSR_MHPM_COUNTER_3H;
    off_evt  = addr_i - CSR_MHPM_EVENT_3;
    off_evth = addr_i - CSR_MHPM_EVENT_3H;
    hit_cnt  = off_cnt  < NumCnt12;
    hit_cnth = off_cnth < NumCnt12;
    hit_evt  = off_evt  < NumCnt12;
    hit_evth = off_evth < NumCnt12;

    sel_cnt = hit_cnt | hit_cnth;
    sel_hi  = hit_cnth | hit_evth;
    // H addresses only exist on RV32.
    mapped  = hit_cnt | hit_evt | (!IsRv64 && sel_hi);

    idx = '0;
    if (hit_cnt)       idx = off_cnt[4:0];
    else if (hit_cnth) idx = off_cnth[4:0];
    else if (hit_evt)  idx = off_evt[4:0];
    else if (hit_evth) idx = off_evth[4:0];

    rd_cnt = '0;
    rd_evt = '0;
    for (int k = 0; k < int'(NumCounters); k++) begin
      if (idx == 5'(k)) begin
        rd_cnt = cnt[k];
        rd_evt = evt[k];
      end
    end
    rd_cur  = sel_cnt ? rd_cnt : rd_evt;
    rd_word = (!IsRv64 && sel_hi) ? {32'h0, rd_cur[63:32]} : rd_cur;
    data_o  = mapped ? XLEN'(rd_word) : '0;

    // On RV32 a half write keeps the other half of the selected register.
    if (IsRv64)      wr_word = data_ext;
    else if (sel_hi) wr_word = {data_ext[31:0], rd_cur[31:0]};
    else             wr_word = {rd_cur[63:32], data_ext[31:0]};

    for (int k = 0; k < int'(NumCounters); k++) begin
      cnt_we[k] = we_i && mapped &&  sel_cnt && (idx == 5'(k));
      evt_we[k] = we_i && mapped && !sel_cnt && (idx == 5'(k));
    end
  end

  // The error flag is a pure address decode; it is forced low while in reset.
  assign access_err_o = rst_ni & ~mapped;

  for (genvar k = 0; k < int'(NumCounters); k++) begin : g_cnt
    hpm_counter #(
      .NumEvents (NumEvents),
      .IncrWidth (IncrWidth)
    ) u_hpm_counter (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .debug_mode_i (debug_mode_i),
      .priv_lvl_i   (priv_lvl_i),
      .inhibit_i    (mcountinhibit_i[3+k]),
      .event_incr_i (event_incr_i),
      .cnt_we_i     (cnt_we[k]),
      .cnt_wdata_i  (wr_word),
      .evt_we_i     (evt_we[k]),
      .evt_wdata_i  (wr_word),
      .cnt_o        (cnt[k]),
      .evt_o        (evt[k]),
      .of_o         (of_bits[k])
    );
  end

  always_comb begin
    ovf_status_o = '0;
    for (int k = 0; k < int'(NumCounters); k++) ovf_status_o[3+k] = of_bits[k];
    ovf_irq_d = |of_bits;
  end

  // NOTE: all architectural state, including every counter slice, is reset
  // so software never observes stale counts after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ovf_irq_q <= 1'b0;
    else         ovf_irq_q <= ovf_irq_d;
  end

  assign ovf_irq_o = ovf_irq_q;

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Directed self-checking bench for hpm_counter_bank (RV64, 6 counters, 32 events).
module tb_hpm_counter_bank;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        debug_mode_i;
  logic [1:0]  priv_lvl_i;
  logic [95:0] event_incr_i;
  logic [31:0] mcountinhibit_i;
  logic [11:0] addr_i;
  logic        we_i;
  logic [63:0] data_i;
  logic [63:0] data_o;
  logic        access_err_o;
  logic [31:0] ovf_status_o;
  logic        ovf_irq_o;

  int n_cmp = 0;
  int n_err = 0;

  hpm_counter_bank #(
    .NumCounters (6),
    .NumEvents   (32),
    .IncrWidth   (3),
    .XLEN        (64)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .debug_mode_i    (debug_mode_i),
    .priv_lvl_i      (priv_lvl_i),
    .event_incr_i    (event_incr_i),
    .mcountinhibit_i (mcountinhibit_i),
    .addr_i          (addr_i),
    .we_i            (we_i),
    .data_i          (data_i),
    .data_o          (data_o),
    .access_err_o    (access_err_o),
    .ovf_status_o    (ovf_status_o),
    .ovf_irq_o       (ovf_irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
    addr_i = a;
    data_i = d;
    we_i   = 1'b1;
    tick();
    we_i   = 1'b0;
  endtask

  task automatic check_rd(input string tag, input logic [11:0] a, input logic [63:0] exp);
    addr_i = a;
    we_i   = 1'b0;
    #1;
    check(tag, data_o, exp);
  endtask

  task automatic set_incr(input int e, input int v);
    event_incr_i = '0;
    event_incr_i[e*3 +: 3] = v[2:0];
  endtask

  initial begin
    rst_ni          = 1'b0;
    debug_mode_i    = 1'b0;
    priv_lvl_i      = 2'b11;
    event_incr_i    = '0;
    mcountinhibit_i = '0;
    addr_i          = 12'hB03;
    we_i            = 1'b0;
    data_i          = '0;

    // Reset state
    repeat (2) @(negedge clk_i);
    check_rd("rst_cnt3", 12'hB03, 64'd0);
    check("rst_err", 64'(access_err_o), 64'd0);
    addr_i = 12'h000;
    #1 check("rst_err_unmapped", 64'(access_err_o), 64'd0);
    check("rst_ovf", 64'(ovf_status_o), 64'd0);
    check("rst_irq", 64'(ovf_irq_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // SEL=5, incr 3 for 10 cycles in M mode
    csr_write(12'h323, 64'd5);
    check_rd("evt3_sel5", 12'h323, 64'd5);
    set_incr(5, 3);
    repeat (10) @(posedge clk_i);
    #1 event_incr_i = '0;
    check_rd("count_30", 12'hB03, 64'd30);

    // Write wins over same-cycle increment; WARL selector; event write keeps count
    set_incr(5, 2);
    csr_write(12'hB03, 64'd100);
    event_incr_i = '0;
    check_rd("wr_beats_incr", 12'hB03, 64'd100);
    csr_write(12'h323, 64'd40);
    check_rd("sel_warl", 12'h323, 64'd0);
    check_rd("evt_wr_keeps_cnt", 12'hB03, 64'd100);

    // Overflow: FFFF..FE + 3 -> 1 with OF, IRQ one cycle later
    csr_write(12'h323, 64'd1);
    csr_write(12'hB03, 64'hFFFF_FFFF_FFFF_FFFE);
    set_incr(1, 3);
    tick();
    event_incr_i = '0;
    check_rd("ovf_wrap", 12'hB03, 64'd1);
    check_rd("ovf_evt_of", 12'h323, 64'h8000_0000_0000_0001);
    check("ovf_status", 64'(ovf_status_o), 64'h8);
    check("irq_not_yet", 64'(ovf_irq_o), 64'd0);
    tick();
    check("irq_set", 64'(ovf_irq_o), 64'd1);
    csr_write(12'h323, 64'd1);
    check("of_cleared", 64'(ovf_status_o), 64'd0);
    check("irq_lag", 64'(ovf_irq_o), 64'd1);
    tick();
    check("irq_drop", 64'(ovf_irq_o), 64'd0);

    // Hardware carry beats a same-cycle software OF clear
    csr_write(12'hB03, 64'hFFFF_FFFF_FFFF_FFFF);
    csr_write(12'h323, 64'h8000_0000_0000_0001);
    set_incr(1, 1);
    csr_write(12'h323, 64'd1);
    event_incr_i = '0;
    check_rd("carry_vs_clr_cnt", 12'hB03, 64'd0);
    check_rd("carry_vs_clr_of", 12'h323, 64'h8000_0000_0000_0001);
    csr_write(12'h323, 64'd0);

    // Inhibit gating
    csr_write(12'h323, 64'h1000_0000_0000_0001);
    csr_write(12'hB03, 64'd0);
    csr_write(12'h324, 64'd1);
    csr_write(12'h325, 64'd1);
    csr_write(12'h326, 64'd1);
    priv_lvl_i      = 2'b00;
    mcountinhibit_i = 32'h10;
    set_incr(1, 1);
    repeat (5) @(posedge clk_i);
    #1 event_incr_i = '0;
    check_rd("uinh_u", 12'hB03, 64'd0);
    check_rd("mcountinhibit4", 12'hB04, 64'd0);
    check_rd("ctrl_counts_u", 12'hB06, 64'd5);
    priv_lvl_i      = 2'b11;
    mcountinhibit_i = '0;
    debug_mode_i    = 1'b1;
    set_incr(1, 1);
    repeat (5) @(posedge clk_i);
    #1 event_incr_i = '0;
    check_rd("debug_cnt5", 12'hB05, 64'd5);
    check_rd("debug_cnt4", 12'hB04, 64'd0);
    check_rd("debug_ctrl", 12'hB06, 64'd5);
    debug_mode_i = 1'b0;
    set_incr(1, 1);
    repeat (3) @(posedge clk_i);
    #1 event_incr_i = '0;
    check_rd("uinh_m_counts", 12'hB03, 64'd3);
    check_rd("resume_ctrl", 12'hB06, 64'd8);

    // Access errors on RV64
    check_rd("h_read_data", 12'hB83, 64'd0);
    check("h_read_err", 64'(access_err_o), 64'd1);
    check_rd("valid_no_err_data", 12'hB06, 64'd8);
    check("valid_no_err", 64'(access_err_o), 64'd0);
    addr_i = 12'hB09;
    data_i = 64'd55;
    we_i   = 1'b1;
    #1 check("oob_wr_err", 64'(access_err_o), 64'd1);
    tick();
    we_i = 1'b0;
    check_rd("oob_rd_data", 12'hB09, 64'd0);
    check_rd("oob_no_change8", 12'hB08, 64'd0);
    check_rd("oob_no_change3", 12'hB03, 64'd3);
    csr_write(12'hB83, 64'd77);
    check_rd("h_wr_no_change", 12'hB03, 64'd3);
    check_rd("evth_err_data", 12'h723, 64'd0);
    check("evth_err", 64'(access_err_o), 64'd1);

    // Event field masking and software OF set
    csr_write(12'h324, 64'hFFFF_FFFF_FFFF_FFFF);
    check_rd("evt_mask", 12'h324, 64'hF000_0000_0000_0000);
    check("sw_of_set", 64'(ovf_status_o), 64'h10);

    // Reset mid-count with OF set
    set_incr(1, 1);
    tick();
    tick();
    check("pre_rst_irq", 64'(ovf_irq_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1 check("rst_irq_now", 64'(ovf_irq_o), 64'd0);
    check("rst_ovf_now", 64'(ovf_status_o), 64'd0);
    for (int k = 0; k < 6; k++) begin
      check_rd($sformatf("rst_cnt%0d", k + 3), 12'hB03 + 12'(k), 64'd0);
      check_rd($sformatf("rst_evt%0d", k + 3), 12'h323 + 12'(k), 64'd0);
    end
    check("rst_err_mid", 64'(access_err_o), 64'd0);
    event_incr_i = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    csr_write(12'h323, 64'd1);
    set_incr(1, 1);
    repeat (4) @(posedge clk_i);
    #1 event_incr_i = '0;
    check_rd("post_rst_count", 12'hB03, 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
